output_vc_credit_tracker: RTL and testbench

- Output-port-side counterpart to input VC selection: for one router output port, allocates downstream VCs to winning packets and tracks per-VC credits.
- Releases each VC after its tail flit has left and all buffer slots are returned.
- One instance per output port; sits between VC/switch allocation and the link to the next router.

---
 rtl/output_vc_credit_tracker.sv | 157 +++++++++++++++
 tb/tb_output_vc_credit_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/output_vc_credit_tracker.sv
// Output-port VC allocator and per-VC downstream credit tracker.
// Grants idle VCs round-robin, counts credits, releases VCs once drained.
module output_vc_credit_tracker #(
  parameter int NUM_VC       = 4,
  parameter int BUFFER_DEPTH = 4,
  parameter int VC_BITS      = $clog2(NUM_VC),
  parameter int CREDIT_BITS  = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_req,
  output logic               alloc_grant,
  output logic [VC_BITS-1:0] alloc_vc,
  input  logic               flit_send,
  input  logic [VC_BITS-1:0] flit_vc,
  input  logic               flit_tail,
  input  logic               credit_in,
  input  logic [VC_BITS-1:0] credit_vc,
  output logic [NUM_VC-1:0]  credit_avail,
  output logic [NUM_VC-1:0]  vc_idle,
  output logic               error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vc_state_e;

  localparam logic [CREDIT_BITS-1:0] FULL =
    CREDIT_BITS'(BUFFER_DEPTH);
  localparam logic [VC_BITS-1:0] LAST_VC =
    VC_BITS'(NUM_VC - 1);

  vc_state_e              state_q [NUM_VC];
  vc_state_e              state_d [NUM_VC];
  logic [CREDIT_BITS-1:0] cnt_q   [NUM_VC];
  logic [CREDIT_BITS-1:0] cnt_d   [NUM_VC];
  logic [VC_BITS-1:0]     ptr_q;
  logic [VC_BITS-1:0]     ptr_d;
  logic                   error_q;
  logic                   error_d;

  logic [NUM_VC-1:0] send_hit;
  logic [NUM_VC-1:0] send_ok;
  logic [NUM_VC-1:0] send_err;
  logic [NUM_VC-1:0] cred_hit;
  logic [NUM_VC-1:0] cred_ok;
  logic [NUM_VC-1:0] cred_err;

  logic               grant;
  logic [VC_BITS-1:0] grant_vc;

  // Registered-state decodes
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      vc_idle[i]      = (state_q[i] == ST_IDLE);
      credit_avail[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin search for the first idle VC at or after the pointer
  always_comb begin
    int idx;
    grant    = 1'b0;
    grant_vc = '0;
    idx      = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = (int'(ptr_q) + k) % NUM_VC;
      if (alloc_req && !grant && vc_idle[idx]) begin
        grant    = 1'b1;
        grant_vc = VC_BITS'(idx);
      end
    end
  end

  assign alloc_grant = grant;
  assign alloc_vc    = grant_vc;

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (grant_vc == LAST_VC) ? '0 : grant_vc + 1'b1;
    end
  end

  // Event qualification per VC
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      send_hit[i] = flit_send && (flit_vc == VC_BITS'(i));
      send_ok[i]  = send_hit[i] && (state_q[i] == ST_ACTIVE) &&
                    (cnt_q[i] != '0);
      send_err[i] = send_hit[i] && !send_ok[i];
      cred_hit[i] = credit_in && (credit_vc == VC_BITS'(i));
      // A same-cycle send frees the slot the credit refills
      cred_ok[i]  = cred_hit[i] && ((cnt_q[i] != FULL) || send_ok[i]);
      cred_err[i] = cred_hit[i] && !cred_ok[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      cnt_d[i] = cnt_q[i] - CREDIT_BITS'(send_ok[i])
                          + CREDIT_BITS'(cred_ok[i]);
    end
  end

  always_comb begin
    error_d = error_q | (|send_err) | (|cred_err);
  end

  // Per-VC lifecycle; release only sees the registered count
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (grant && (grant_vc == VC_BITS'(i))) begin
            state_d[i] = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (send_ok[i] && flit_tail) begin
            state_d[i] = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_q[i] == FULL) begin
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= FULL;
      end
      ptr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ptr_q   <= ptr_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// Directed bench for output_vc_credit_tracker.
// Linear steps with hand-computed expectations, checked by assertions.
module tb_output_vc_credit_tracker;

  logic       clk;
  logic       reset;
  logic       alloc_req;
  logic       alloc_grant;
  logic [1:0] alloc_vc;
  logic       flit_send;
  logic [1:0] flit_vc;
  logic       flit_tail;
  logic       credit_in;
  logic [1:0] credit_vc;
  logic [3:0] credit_avail;
  logic [3:0] vc_idle;
  logic       error;

  int vectors;
  int miscompares;

  output_vc_credit_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_vc     (alloc_vc),
    .flit_send    (flit_send),
    .flit_vc      (flit_vc),
    .flit_tail    (flit_tail),
    .credit_in    (credit_in),
    .credit_vc    (credit_vc),
    .credit_avail (credit_avail),
    .vc_idle      (vc_idle),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and return inputs to idle
  task automatic cyc();
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    flit_send = 1'b0;
    flit_tail = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic send(input logic [1:0] vc, input logic tail);
    flit_send = 1'b1;
    flit_vc   = vc;
    flit_tail = tail;
  endtask

  task automatic credit(input logic [1:0] vc);
    credit_in = 1'b1;
    credit_vc = vc;
  endtask

  task automatic req_chk(input string tag,
                         input logic g,
                         input logic [1:0] v);
    alloc_req = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(alloc_grant), 32'(g));
    chk({tag, "_vc"}, 32'(alloc_vc), 32'(v));
    cyc();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc();
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    alloc_req   = 1'b0;
    flit_send   = 1'b0;
    flit_vc     = 2'd0;
    flit_tail   = 1'b0;
    credit_in   = 1'b0;
    credit_vc   = 2'd0;

    // Reset state
    do_reset(2);
    #1;
    chk("rst_idle", 32'(vc_idle), 32'hF);
    chk("rst_cred", 32'(credit_avail), 32'hF);
    chk("rst_err", 32'(error), 32'h0);
    chk("rst_grant", 32'(alloc_grant), 32'h0);
    chk("rst_vc", 32'(alloc_vc), 32'h0);

    // Round-robin allocation, fifth request finds nothing idle
    req_chk("rr0", 1'b1, 2'd0);
    req_chk("rr1", 1'b1, 2'd1);
    req_chk("rr2", 1'b1, 2'd2);
    req_chk("rr3", 1'b1, 2'd3);
    req_chk("rr4", 1'b0, 2'd0);
    chk("rr_idle", 32'(vc_idle), 32'h0);

    // Credit exhaustion on VC2
    send(2'd2, 1'b0); cyc();
    send(2'd2, 1'b0); cyc();
    send(2'd2, 1'b0); cyc();
    chk("ex3_cred", 32'(credit_avail), 32'hF);
    send(2'd2, 1'b0); cyc();
    chk("ex4_cred", 32'(credit_avail), 32'hB);
    chk("ex4_err", 32'(error), 32'h0);
    send(2'd2, 1'b0); cyc();
    chk("ex5_err", 32'(error), 32'h1);
    chk("ex5_cred", 32'(credit_avail), 32'hB);
    cyc();
    chk("ex_sticky", 32'(error), 32'h1);

    // Drain and release of VC1
    do_reset(1);
    repeat (4) begin
      alloc_req = 1'b1;
      cyc();
    end
    chk("dr_alloc", 32'(vc_idle), 32'h0);
    send(2'd1, 1'b0); cyc();
    send(2'd1, 1'b1); cyc();
    chk("dr_tail_idle", 32'(vc_idle), 32'h0);
    credit(2'd1); cyc();
    chk("dr_c1_idle", 32'(vc_idle), 32'h0);
    credit(2'd1); cyc();
    chk("dr_c2_idle", 32'(vc_idle), 32'h0);
    cyc();
    chk("dr_rel_idle", 32'(vc_idle), 32'h2);
    chk("dr_err", 32'(error), 32'h0);
    req_chk("dr_realloc", 1'b1, 2'd1);
    chk("dr_re_idle", 32'(vc_idle), 32'h0);

    // Tail with a full counter still spends one cycle draining
    send(2'd1, 1'b1);
    credit(2'd1);
    cyc();
    chk("tf_idle", 32'(vc_idle), 32'h0);
    chk("tf_err", 32'(error), 32'h0);
    cyc();
    chk("tf_rel", 32'(vc_idle), 32'h2);
    req_chk("tf_realloc", 1'b1, 2'd1);

    // Same-cycle send and credit on VC0 nets to zero
    send(2'd0, 1'b0); cyc();
    send(2'd0, 1'b0); cyc();
    send(2'd0, 1'b0);
    credit(2'd0);
    cyc();
    chk("sim_err", 32'(error), 32'h0);
    send(2'd0, 1'b0); cyc();
    chk("sim_c1", 32'(credit_avail), 32'hF);
    send(2'd0, 1'b0); cyc();
    chk("sim_c0", 32'(credit_avail), 32'hE);
    chk("sim_err2", 32'(error), 32'h0);
    credit(2'd3); cyc();
    chk("ovf_err", 32'(error), 32'h1);
    chk("ovf_cred", 32'(credit_avail), 32'hE);

    // Reset overrides a concurrent request
    reset     = 1'b1;
    alloc_req = 1'b1;
    credit(2'd0);
    cyc();
    reset = 1'b0;
    chk("ro_idle", 32'(vc_idle), 32'hF);
    chk("ro_err", 32'(error), 32'h0);

    // Reset mid-operation
    alloc_req = 1'b1; cyc();
    alloc_req = 1'b1; cyc();
    send(2'd0, 1'b0); cyc();
    send(2'd0, 1'b0); cyc();
    send(2'd1, 1'b0); cyc();
    chk("mid_idle", 32'(vc_idle), 32'hC);
    do_reset(1);
    chk("mid_rst_idle", 32'(vc_idle), 32'hF);
    chk("mid_rst_cred", 32'(credit_avail), 32'hF);
    chk("mid_rst_err", 32'(error), 32'h0);
    req_chk("mid_alloc", 1'b1, 2'd0);

    // Send to an idle VC is rejected and flagged
    send(2'd2, 1'b0); cyc();
    chk("idle_send_err", 32'(error), 32'h1);
    chk("idle_send_cred", 32'(credit_avail), 32'hF);
    chk("idle_send_st", 32'(vc_idle), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
